breath_key_ctrl: RTL

BREATH_KEY_CTRL -- requirements
Module: breath_key_ctrl

---
 rtl/breath_key_ctrl_pkg.sv | 42 ++++
 rtl/breath_key_ctrl_if.sv | 15 +
 rtl/breath_key_ctrl_key_debounce.sv | 49 ++++
 rtl/breath_key_ctrl.sv | 83 ++++++++
 4 files changed

// File: rtl/breath_key_ctrl_pkg.sv
// Shared definitions for the breath-LED control blocks: mode state
// encodings, speed_sel codes and the mode-step function.
package breath_key_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_SLOW = 2'b01,
        MODE_MID  = 2'b10,
        MODE_FAST = 2'b11
    } mode_t;

    localparam logic [1:0] SPEED_OFF  = 2'b00;
    localparam logic [1:0] SPEED_SLOW = 2'b01;
    localparam logic [1:0] SPEED_MID  = 2'b10;
    localparam logic [1:0] SPEED_FAST = 2'b11;

    // Long press always wins and returns to OFF; short press steps through
    // the speeds, wrapping FAST back to SLOW rather than to OFF.
    function automatic mode_t next_mode(mode_t cur, logic short_evt, logic long_evt);
        next_mode = cur;
        if (long_evt) begin
            next_mode = MODE_OFF;
        end else if (short_evt) begin
            case (cur)
                MODE_OFF:  next_mode = MODE_SLOW;
                MODE_SLOW: next_mode = MODE_MID;
                MODE_MID:  next_mode = MODE_FAST;
                default:   next_mode = MODE_SLOW;
            endcase
        end
    endfunction

    function automatic logic [1:0] speed_of(mode_t m);
        case (m)
            MODE_OFF:  speed_of = SPEED_OFF;
            MODE_SLOW: speed_of = SPEED_SLOW;
            MODE_MID:  speed_of = SPEED_MID;
            default:   speed_of = SPEED_FAST;
        endcase
    endfunction

endpackage

// File: rtl/breath_key_ctrl_if.sv
// Key/mode bus between the key controller and its environment.
//   key_in    : raw push-button, low = pressed
//   breath_en : breathing stage enable
//   speed_sel : 00 off, 01 slow, 10 mid, 11 fast
//   mode_chg  : one-cycle pulse on every mode change
// master = environment side, slave = breath_key_ctrl side.
interface breath_key_ctrl_if;
    logic       key_in;
    logic       breath_en;
    logic [1:0] speed_sel;
    logic       mode_chg;

    modport master (output key_in, input breath_en, input speed_sel, input mode_chg);
    modport slave  (input key_in, output breath_en, output speed_sel, output mode_chg);
endinterface

// File: rtl/breath_key_ctrl_key_debounce.sv
// Two-flop synchroniser plus counter debouncer for an active-low key.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   key_in             : raw asynchronous key
//   key_db             : debounced level (1 = released)
//   key_press          : high in the cycle before key_db falls
//   key_release        : high in the cycle before key_db rises
module key_debounce #(
    parameter logic [19:0] CNT_DB_MAX = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_db,
    output logic key_press,
    output logic key_release
);

    logic        sync_q1;
    logic        key_s;
    logic [19:0] db_cnt;
    logic        flip;

    // Edges are taken from registered state only, so key_in never reaches
    // an output combinationally.
    assign flip        = (key_s != key_db) && (db_cnt == CNT_DB_MAX);
    assign key_press   = flip && !key_s;
    assign key_release = flip && key_s;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync_q1 <= 1'b1;
            key_s   <= 1'b1;
            key_db  <= 1'b1;
            db_cnt  <= '0;
        end else begin
            sync_q1 <= key_in;
            key_s   <= sync_q1;
            if (key_s == key_db) begin
                db_cnt <= '0;
            end else if (flip) begin
                key_db <= key_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 20'd1;
            end
        end
    end

endmodule

// File: rtl/breath_key_ctrl.sv
// Single-key mode controller for a breathing LED: short press steps the
// speed, long press turns the LED off.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   bus (slave)        : key_in in; breath_en, speed_sel, mode_chg out,
//                        all outputs registered
module breath_key_ctrl
    import breath_key_ctrl_pkg::*;
#(
    parameter logic [19:0] CNT_DB_MAX   = 20'd999_999,
    parameter logic [25:0] CNT_LONG_MAX = 26'd49_999_999
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    breath_key_ctrl_if.slave  bus
);

    logic        key_db;
    logic        key_press;
    logic        key_release;
    logic [25:0] hold_cnt;
    logic        long_done;
    logic        long_evt;
    logic        short_evt;
    mode_t       mode;
    mode_t       mode_nxt;
    logic        breath_en;
    logic [1:0]  speed_sel;
    logic        mode_chg;

    key_debounce #(.CNT_DB_MAX(CNT_DB_MAX)) u_key_debounce (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_in      (bus.key_in),
        .key_db      (key_db),
        .key_press   (key_press),
        .key_release (key_release)
    );

    // A release landing on the threshold cycle counts as long, never both.
    assign long_evt  = !key_db && (hold_cnt == CNT_LONG_MAX) && !long_done;
    assign short_evt = key_release && !long_done && !long_evt;
    assign mode_nxt  = next_mode(mode, short_evt, long_evt);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
        end else begin
            if (key_press) begin
                hold_cnt <= '0;
            end else if (!key_db && (hold_cnt != CNT_LONG_MAX)) begin
                hold_cnt <= hold_cnt + 26'd1;
            end
            if (key_release) begin
                long_done <= 1'b0;
            end else if (long_evt) begin
                long_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            mode      <= MODE_OFF;
            breath_en <= 1'b0;
            speed_sel <= SPEED_OFF;
            mode_chg  <= 1'b0;
        end else begin
            mode_chg <= 1'b0;
            if (mode_nxt != mode) begin
                mode      <= mode_nxt;
                mode_chg  <= 1'b1;
                speed_sel <= speed_of(mode_nxt);
                breath_en <= (mode_nxt != MODE_OFF);
            end
        end
    end

    assign bus.breath_en = breath_en;
    assign bus.speed_sel = speed_sel;
    assign bus.mode_chg  = mode_chg;

endmodule
